// File: rtl/m72_upload_pkg.sv
// Shared types and helpers for the ROM upload (HPS read-back) path.
package m72_upload_pkg;

  typedef logic [1:0] upload_state_t;

  localparam upload_state_t StIdle  = 2'd0;
  localparam upload_state_t StFetch = 2'd1;
  localparam upload_state_t StDone  = 2'd2;

  localparam logic BYTE_LO_SEL = 1'b0;

  // Even byte address selects the low byte, matching the download writer.
  function automatic logic [7:0] sel_byte(input logic [15:0] word, input logic lsb);
    return (lsb == BYTE_LO_SEL) ? word[7:0] : word[15:8];
  endfunction

endpackage

// File: rtl/toggle_handshake_init.sv
// Initiator side of a toggle req/ack handshake; optional watchdog under ROM_UPLOAD_TIMEOUT_EN.
module toggle_handshake_init #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_i,
  input  logic arm_i,
  input  logic ack_i,
  output logic req_o,
  output logic ready_o,
  output logic done_o,
  output logic timeout_o
);

  // Not reset: parity must stay aligned with the responder across resets.
  logic req_q = 1'b0;
  logic busy_q;
  logic pending_q;
  logic match;

  assign match   = (ack_i == req_q);
  assign ready_o = ~busy_q & (~pending_q | match);
  assign done_o  = busy_q & match;
  assign req_o   = req_q;

  always_ff @(posedge clk_i) begin
    if (start_i && ready_o) begin
      req_q <= ~req_q;
    end
  end

  // Pending blocks new toggles until an orphaned request has been acknowledged.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_q    <= 1'b0;
      pending_q <= 1'b1;
    end else begin
      if (start_i && ready_o) begin
        busy_q <= 1'b1;
      end else if (done_o || timeout_o) begin
        busy_q <= 1'b0;
      end
      if (timeout_o) begin
        pending_q <= 1'b1;
      end else if (pending_q && match) begin
        pending_q <= 1'b0;
      end
    end
  end

`ifdef ROM_UPLOAD_TIMEOUT_EN
  localparam int unsigned TimerW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TimerW-1:0] timer_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      timer_q <= '0;
    end else if (!arm_i || done_o) begin
      timer_q <= '0;
    end else if (!timeout_o) begin
      timer_q <= timer_q + 1'b1;
    end
  end

  assign timeout_o = arm_i & ~done_o & (timer_q == TimerW'(TIMEOUT_CYCLES - 1));
`else
  localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;
  logic unused_arm;

  assign unused_arm = arm_i;
  assign timeout_o  = 1'b0;
`endif

endmodule

// File: rtl/rom_upload_reader.sv
// Serves HPS upload byte reads from a one-word cache backed by a toggle-handshake SDRAM port.
// Optional watchdog on the fetch: define ROM_UPLOAD_TIMEOUT_EN.
module rom_upload_reader
  import m72_upload_pkg::*;
#(
  parameter logic [7:0]  UPLOAD_INDEX   = 8'd0,
  parameter int unsigned ADDR_W         = 25,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_upload,
  input  logic              ioctl_download,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_rd,
  input  logic [ADDR_W-1:0] ioctl_addr,
  output logic [7:0]        ioctl_din,
  output logic              ioctl_wait,
  output logic [ADDR_W-2:0] sdr_addr,
  output logic              sdr_req,
  input  logic              sdr_ack,
  input  logic [15:0]       sdr_dout,
  output logic [15:0]       rd_count
);

  upload_state_t     state_q, state_d;
  logic [7:0]        din_q, din_d;
  logic              wait_q, wait_d;
  logic [ADDR_W-2:0] saddr_q, saddr_d;
  logic              lsb_q, lsb_d;
  logic              issued_q, issued_d;
  logic              kill_q, kill_d;
  logic [15:0]       cache_q, cache_d;
  logic [ADDR_W-2:0] cache_addr_q, cache_addr_d;
  logic              cache_valid_q, cache_valid_d;
  logic [15:0]       count_q, count_d;
  logic              upl_q;

  logic        sel;
  logic        clear;
  logic        hit;
  logic [15:0] count_inc;
  logic        hs_start;
  logic        hs_ready;
  logic        hs_done;
  logic        hs_timeout;

  assign sel       = ioctl_upload & (ioctl_index == UPLOAD_INDEX);
  assign clear     = (upl_q & ~ioctl_upload) | ioctl_download;
  assign hit       = cache_valid_q & (ioctl_addr[ADDR_W-1:1] == cache_addr_q);
  assign count_inc = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;

  toggle_handshake_init #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_handshake (
    .clk_i    (clk_sys),
    .rst_i    (reset),
    .start_i  (hs_start),
    .arm_i    (state_q == StFetch),
    .ack_i    (sdr_ack),
    .req_o    (sdr_req),
    .ready_o  (hs_ready),
    .done_o   (hs_done),
    .timeout_o(hs_timeout)
  );

  always_comb begin
    state_d       = state_q;
    din_d         = din_q;
    wait_d        = wait_q;
    saddr_d       = saddr_q;
    lsb_d         = lsb_q;
    issued_d      = issued_q;
    kill_d        = kill_q;
    cache_d       = cache_q;
    cache_addr_d  = cache_addr_q;
    cache_valid_d = cache_valid_q;
    count_d       = count_q;
    hs_start      = 1'b0;

    case (state_q)
      StIdle: begin
        if (ioctl_rd && sel) begin
          if (hit) begin
            din_d   = sel_byte(cache_q, ioctl_addr[0]);
            count_d = count_inc;
          end else begin
            wait_d   = 1'b1;
            saddr_d  = ioctl_addr[ADDR_W-1:1];
            lsb_d    = ioctl_addr[0];
            hs_start = 1'b1;
            issued_d = hs_ready;
            kill_d   = 1'b0;
            state_d  = StFetch;
          end
        end
      end
      StFetch: begin
        if (hs_done) begin
          din_d = sel_byte(sdr_dout, lsb_q);
          if (!kill_q && !clear) begin
            cache_d       = sdr_dout;
            cache_addr_d  = saddr_q;
            cache_valid_d = 1'b1;
          end
          state_d = StDone;
        end else if (hs_timeout) begin
          din_d   = 8'hFF;
          state_d = StDone;
        end else if (!issued_q) begin
          // Request was held off by an orphaned handshake; issue once it closes.
          hs_start = 1'b1;
          issued_d = hs_ready;
        end
      end
      StDone: begin
        wait_d  = 1'b0;
        count_d = count_inc;
        state_d = StIdle;
      end
      default: begin
        wait_d  = 1'b0;
        state_d = StIdle;
      end
    endcase

    if (clear) begin
      cache_valid_d = 1'b0;
      count_d       = 16'd0;
      kill_d        = 1'b1;
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      din_q         <= 8'd0;
      wait_q        <= 1'b0;
      saddr_q       <= '0;
      lsb_q         <= 1'b0;
      issued_q      <= 1'b0;
      kill_q        <= 1'b0;
      cache_q       <= 16'd0;
      cache_addr_q  <= '0;
      cache_valid_q <= 1'b0;
      count_q       <= 16'd0;
      upl_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      din_q         <= din_d;
      wait_q        <= wait_d;
      saddr_q       <= saddr_d;
      lsb_q         <= lsb_d;
      issued_q      <= issued_d;
      kill_q        <= kill_d;
      cache_q       <= cache_d;
      cache_addr_q  <= cache_addr_d;
      cache_valid_q <= cache_valid_d;
      count_q       <= count_d;
      upl_q         <= ioctl_upload;
    end
  end

  assign ioctl_din  = din_q;
  assign ioctl_wait = wait_q;
  assign sdr_addr   = saddr_q;
  assign rd_count   = count_q;

endmodule

// File: doc/rom_upload_reader.md
Name: rom_upload_reader

Overview:
- Read-side counterpart of the ioctl ROM download path.
- Services HPS upload reads (ioctl_upload/ioctl_rd) by fetching 16-bit words from an SDRAM channel using the same toggle req/ack handshake the download writer uses.
- Returns the addressed byte on ioctl_din and holds ioctl_wait while a fetch is outstanding.
- Sits in emu between hps_io and a spare sdram port (addr/dout/req/ack), clocked by clk_sys.

Parameters:
- UPLOAD_INDEX, 8'd0, ioctl_index value this block responds to.
- ADDR_W, 25, byte address width of ioctl_addr.
- TIMEOUT_CYCLES, 1024, watchdog limit in clk_sys cycles (used only with the optional feature).

Ports:
- clk_sys  in  1  system clock (CLK_32M).
- reset  in  1  asynchronous, active-high reset.
- ioctl_upload  in  1  upload session active.
- ioctl_download  in  1  download session active; invalidates the word cache.
- ioctl_index  in  8  current transfer index.
- ioctl_rd  in  1  one-cycle byte read strobe.
- ioctl_addr  in  ADDR_W  byte address of the read.
- ioctl_din  out  8  byte returned to HPS.
- ioctl_wait  out  1  stall the HPS while a fetch is pending.
- sdr_addr  out  ADDR_W-1  word address, [ADDR_W-1:1].
- sdr_req  out  1  toggle request.
- sdr_ack  in  1  toggle acknowledge; equals sdr_req when the request is done.
- sdr_dout  in  16  read data, valid when sdr_ack==sdr_req.
- rd_count  out  16  number of bytes served in the current session (debug/LED).

Behaviour:
- Reset values:
  - ioctl_din=0, ioctl_wait=0, sdr_addr=0, rd_count=0.
  - State IDLE, cache_valid=0.
  - sdr_req has power-up value 0 and is NOT cleared by reset, so toggle parity stays aligned with the responder.
- Selection: sel = ioctl_upload & (ioctl_index==UPLOAD_INDEX).
- FSM states: IDLE, FETCH, DONE.
- IDLE:
  - On ioctl_rd & sel, latch addr = ioctl_addr.
  - Cache hit (cache_valid and addr[ADDR_W-1:1]==cache_addr): next cycle ioctl_din = addr[0] ? cache[15:8] : cache[7:0]. rd_count+1. ioctl_wait stays 0. Stay IDLE.
  - Miss: next cycle ioctl_wait=1, sdr_addr=addr[ADDR_W-1:1], sdr_req toggles, go to FETCH.
- FETCH:
  - Wait until sdr_ack==sdr_req, with no other condition.
  - That cycle: cache<=sdr_dout, cache_addr<=sdr_addr, cache_valid<=1.
  - ioctl_din gets the byte selected as above; go to DONE.
- DONE:
  - Next cycle ioctl_wait=0, rd_count+1, go to IDLE.
  - Miss latency from the rd strobe: 1 cycle + SDRAM handshake + 2 cycles.
- Byte order matches the writer: even address = low byte [7:0], odd address = high byte [15:8].
- ioctl_rd while not IDLE is ignored. ioctl_rd with sel=0 is ignored.
- Falling edge of ioctl_upload, or any cycle with ioctl_download=1:
  - cache_valid<=0, rd_count<=0.
  - An in-flight FETCH still completes its handshake: the state machine continues, ioctl_din is updated, and the cache fill is suppressed.
- Reset mid-FETCH:
  - Returns to IDLE with wait=0.
  - The outstanding toggle completes on the responder side. On the next miss, the FSM must first wait for sdr_ack==sdr_req before toggling. A dedicated flag, pending, is set on reset when sdr_ack!=sdr_req and blocks the IDLE miss path until they match.
- rd_count saturates at 16'hFFFF.

Optional Feature:
- Macro: ROM_UPLOAD_TIMEOUT_EN.
- With the macro: a watchdog counts cycles in FETCH. At TIMEOUT_CYCLES it forces ioctl_din=8'hFF, leaves cache_valid=0, sets pending, and goes to DONE so the HPS never hangs.
- Without the macro: FETCH waits indefinitely and no counter is synthesized.

Decomposition:
- Package m72_upload_pkg holds:
  - state enum upload_state_t {IDLE, FETCH, DONE};
  - localparam BYTE_LO_SEL = 1'b0.
- One natural sub-module: toggle_handshake_init. It owns sdr_req, the pending flag, a done pulse (sdr_ack==sdr_req after a toggle), and the optional timeout counter. It is reusable for the writer side.

Test Plan:
- Miss then hit:
  - Stimulus: upload index 0, rd at addr 0x000010; responder returns 16'hBEEF after 5 cycles; then rd at addr 0x000011.
  - Required response: ioctl_din=8'hEF, with wait high from cycle 1 through ack+1. Second read gives ioctl_din=8'hBE with no wait and no sdr_req toggle.
- Word boundary:
  - Stimulus: rd at 0x000011, then rd at 0x000012.
  - Required response: the second read toggles sdr_req with sdr_addr=0x000009; rd_count=2.
- Index filter:
  - Stimulus: ioctl_index=1, rd strobe.
  - Required response: no toggle, wait=0, ioctl_din unchanged.
- Session end:
  - Stimulus: drop ioctl_upload after a hit, restart, rd at the same address.
  - Required response: a fetch is issued (cache invalid) and rd_count restarts from 0.
- Reset mid-FETCH:
  - Stimulus: assert reset 3 cycles after the toggle; responder acks 10 cycles later; issue a new rd in between.
  - Required response: the new toggle occurs only after the old ack and returns the correct byte.
- Timeout (ROM_UPLOAD_TIMEOUT_EN, TIMEOUT_CYCLES=16):
  - Stimulus: the responder never acks.
  - Required response: wait drops after 16+2 cycles with ioctl_din=8'hFF.
